// File: rtl/router_reg.sv
// router_reg: datapath register stage of the 1x3 router (header capture, stall hold, XOR parity).
// Define ROUTER_PKT_CNT_EN to add saturating good/bad packet counters.
module router_reg #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             pkt_valid,
    input  logic [7:0]       data_in,
    input  logic             fifo_full,
    input  logic             detect_add,
    input  logic             lfd_state,
    input  logic             ld_state,
    input  logic             laf_state,
    input  logic             full_state,
    input  logic             rst_int_reg,
    output logic [7:0]       dout,
    output logic             parity_done,
    output logic             low_pkt_valid,
    output logic             err
`ifdef ROUTER_PKT_CNT_EN
    ,
    output logic [CNT_W-1:0] good_pkt_cnt,
    output logic [CNT_W-1:0] bad_pkt_cnt
`endif
);

    logic [7:0] hdr;
    logic [7:0] hold;
    logic [7:0] int_par;
    logic [7:0] pkt_par;
    logic       par_check;
    logic       par_mismatch;
    logic       par_byte;

    assign par_check    = rst_int_reg && parity_done;
    assign par_mismatch = (int_par != pkt_par);
    assign par_byte     = ld_state && !pkt_valid;

    always_ff @(posedge clock) begin
        if (!resetn)
            hdr <= '0;
        else if (detect_add && pkt_valid)
            hdr <= data_in;
    end

    // Byte presented during a full stall is parked in hold and replayed on LOAD_AFTER_FULL.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            dout <= '0;
            hold <= '0;
        end else if (lfd_state) begin
            dout <= hdr;
        end else if (ld_state && !fifo_full) begin
            dout <= data_in;
        end else if (ld_state && fifo_full) begin
            hold <= data_in;
        end else if (laf_state) begin
            dout <= hold;
        end
    end

    // Held bytes are counted when captured, so LOAD_AFTER_FULL leaves parity alone.
    always_ff @(posedge clock) begin
        if (!resetn)
            int_par <= '0;
        else if (detect_add)
            int_par <= '0;
        else if (lfd_state)
            int_par <= int_par ^ hdr;
        else if (ld_state && pkt_valid && !full_state)
            int_par <= int_par ^ data_in;
    end

    always_ff @(posedge clock) begin
        if (!resetn)
            pkt_par <= '0;
        else if (par_byte)
            pkt_par <= data_in;
    end

    always_ff @(posedge clock) begin
        if (!resetn)
            low_pkt_valid <= 1'b0;
        else if (par_byte)
            low_pkt_valid <= 1'b1;
        else if (rst_int_reg)
            low_pkt_valid <= 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!resetn)
            parity_done <= 1'b0;
        else if ((par_byte && !fifo_full) || (laf_state && low_pkt_valid && !parity_done))
            parity_done <= 1'b1;
        else if (detect_add)
            parity_done <= 1'b0;
    end

    // Sticky until the next packet's first data load.
    always_ff @(posedge clock) begin
        if (!resetn)
            err <= 1'b0;
        else if (par_check)
            err <= par_mismatch;
        else if (lfd_state)
            err <= 1'b0;
    end

`ifdef ROUTER_PKT_CNT_EN
    always_ff @(posedge clock) begin
        if (!resetn)
            good_pkt_cnt <= '0;
        else if (par_check && !par_mismatch && (good_pkt_cnt != '1))
            good_pkt_cnt <= good_pkt_cnt + CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (!resetn)
            bad_pkt_cnt <= '0;
        else if (par_check && par_mismatch && (bad_pkt_cnt != '1))
            bad_pkt_cnt <= bad_pkt_cnt + CNT_W'(1);
    end
`endif

endmodule
